// File: rtl/input_conditioner_if.sv
// Signal bundle between a raw-level source and the input conditioner.
// The master drives the raw level. The slave (the conditioner) returns the clean
// level, the edge pulses and the rising-edge count.
`timescale 1ns/100ps
interface input_conditioner_if #(
  parameter int CNT_W = 8
);
  logic             data_in;
  logic             data_out;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] rise_count;

  modport master (
    output data_in,
    input  data_out,
    input  rise,
    input  fall,
    input  rise_count
  );

  modport slave (
    input  data_in,
    output data_out,
    output rise,
    output fall,
    output rise_count
  );
endinterface

// File: rtl/input_conditioner.sv
// Input conditioner. It synchronises a raw asynchronous level into clk, then
// debounces it. It emits the clean level plus registered one-cycle rise/fall
// pulses, and counts accepted rising edges (the count wraps).
`timescale 1ns/100ps
module input_conditioner #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_LEVEL     = 1'b0,
  parameter int   CNT_W           = 8
) (
  input logic             clk,
  input logic             reset_n,
  input_conditioner_if.slave bus
);

  // Debounce counter width. It is at least one bit, so DEBOUNCE_CYCLES=1 still has a legal vector.
  localparam int CNT_BITS = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 1) begin : g_bad_sync
    $error("input_conditioner: SYNC_STAGES must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [CNT_W-1:0]       count_q, count_d;

  // The synchroniser is a plain shift chain with no logic between stages.
  if (SYNC_STAGES == 1) begin : g_sync1
    // Single-flop synchroniser.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= RESET_LEVEL;
      else          sync_q <= bus.data_in;
    end
  end else begin : g_syncn
    // Multi-flop synchroniser. sync_q[0] takes the raw level.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], bus.data_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce decision. The output accepts s only after DEBOUNCE_CYCLES
  // consecutive mismatching edges. Any match in between clears the run.
  always_comb begin
    cnt_d   = '0;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    count_d = count_q;
    if (s != out_q) begin
      if (cnt_q == CNT_MAX) begin
        out_d  = s;
        rise_d = s;
        fall_d = ~s;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_BITS'(1);
      end
    end
    if (rise_d) count_d = count_q + CNT_W'(1);
  end

  // State and output registers. Reset forces no pulse and zero count, so
  // releasing reset never produces an edge by itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      out_q   <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
    end
  end

  assign bus.data_out   = out_q;
  assign bus.rise       = rise_q;
  assign bus.fall       = fall_q;
  assign bus.rise_count = count_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner. It runs three configurations side by side on one raw input:
// the default build, a 2-bit counter build, and a 3-stage/no-filter build.
// A history-based reference model predicts every output after every edge.
`timescale 1ns/100ps
module tb_input_conditioner;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  logic din;
  always #2 clk = ~clk;

  input_conditioner_if #(.CNT_W(8)) if_def ();
  input_conditioner_if #(.CNT_W(2)) if_wrap ();
  input_conditioner_if #(.CNT_W(8)) if_fast ();

  assign if_def.data_in  = din;
  assign if_wrap.data_in = din;
  assign if_fast.data_in = din;

  input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0), .CNT_W(8))
    u_def  (.clk(clk), .reset_n(reset_n), .bus(if_def));
  input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0), .CNT_W(2))
    u_wrap (.clk(clk), .reset_n(reset_n), .bus(if_wrap));
  input_conditioner #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0), .CNT_W(8))
    u_fast (.clk(clk), .reset_n(reset_n), .bus(if_fast));

  // ---------------- reference model ----------------
  // The model keeps every raw sample since reset. The level seen by the debouncer
  // at edge j is the raw sample from SYNC edges earlier. The output flips at edge k
  // when the last DEBOUNCE edges all disagreed with it and it has not changed
  // within that window.
  int sync_n[3] = '{2, 2, 3};
  int deb_n[3]  = '{4, 4, 1};
  int cnt_w[3]  = '{8, 2, 8};

  bit din_q[$];
  int edge_k;
  bit m_out[3];
  bit m_rise[3];
  bit m_fall[3];
  int m_count[3];
  int m_last[3];
  int m_cnt[3];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit s_pre(int i, int j);
    int idx;
    idx = j - sync_n[i];
    if (idx >= 0) return din_q[idx];
    return 1'b0;
  endfunction

  task automatic model_reset();
    din_q.delete();
    edge_k = 0;
    for (int i = 0; i < 3; i++) begin
      m_out[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0;
      m_count[i] = 0; m_last[i] = -1; m_cnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    int k;
    int run;
    din_q.push_back(din);
    k = edge_k;
    for (int i = 0; i < 3; i++) begin
      run = 0;
      for (int j = k; j > m_last[i] && run < deb_n[i]; j--) begin
        if (s_pre(i, j) != m_out[i]) run++;
        else break;
      end
      if (run >= deb_n[i]) begin
        m_rise[i] = !m_out[i];
        m_fall[i] = m_out[i];
        m_out[i]  = !m_out[i];
        m_last[i] = k;
        m_cnt[i]  = 0;
        if (m_rise[i]) m_count[i] = (m_count[i] + 1) % (1 << cnt_w[i]);
      end else begin
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        m_cnt[i]  = run;
      end
    end
    edge_k++;
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic cmp_inst(input string nm, input int i, input logic o, input logic r,
                          input logic f, input logic [31:0] c, input logic [31:0] dc);
    check({nm, ".data_out"},   32'(o), 32'(m_out[i]));
    check({nm, ".rise"},       32'(r), 32'(m_rise[i]));
    check({nm, ".fall"},       32'(f), 32'(m_fall[i]));
    check({nm, ".rise_count"}, c,      m_count[i]);
    check({nm, ".cnt"},        dc,     m_cnt[i]);
  endtask

  task automatic compare_all();
    cmp_inst("def",  0, if_def.data_out,  if_def.rise,  if_def.fall,
             32'(if_def.rise_count),  32'(u_def.cnt_q));
    cmp_inst("wrap", 1, if_wrap.data_out, if_wrap.rise, if_wrap.fall,
             32'(if_wrap.rise_count), 32'(u_wrap.cnt_q));
    cmp_inst("fast", 2, if_fast.data_out, if_fast.rise, if_fast.fall,
             32'(if_fast.rise_count), 32'(u_fast.cnt_q));
  endtask

  // ---------------- driver tasks ----------------
  // The raw level is set after an edge. The DUT samples it on the next edge,
  // and the outputs are compared 1 ns later.
  task automatic step(input bit d);
    din = d;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Called 1 ns after an edge. Asserts reset mid-cycle and releases it on the falling edge.
  task automatic do_reset(input bit d);
    din = d;
    reset_n = 1'b0;
    model_reset();
    #0.5;
    compare_all();
    @(negedge clk);
    compare_all();
    reset_n = 1'b1;
    #0.5;
    compare_all();
  endtask

  task automatic run_edge(input bit d, input int n, output int f_def, output int f_fast,
                          output int pulses);
    f_def = -1; f_fast = -1; pulses = 0;
    for (int e = 0; e < n; e++) begin
      step(d);
      if (f_def < 0 && if_def.data_out == d) f_def = e;
      if (f_fast < 0 && if_fast.data_out == d) f_fast = e;
      if (d ? if_def.rise : if_def.fall) pulses++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fd, ff, p, p2, guard;
    bit d;
    int exp_wrap[5];
    exp_wrap = '{1, 2, 3, 0, 1};

    // Reset held with the raw level already high.
    reset_n = 1'b1;
    din = 1'b1;
    model_reset();
    #0.5 reset_n = 1'b0;
    #0.5 compare_all();
    check("rst_out_const", 32'(if_def.data_out), 0);
    #2.5 compare_all();
    reset_n = 1'b1;
    #0.5 compare_all();
    check("rel_no_rise", 32'(if_def.rise), 0);
    run_edge(1'b1, 8, fd, ff, p);
    check("rst_latency_def", fd, 5);
    check("rst_latency_fast", ff, 3);
    check("rst_rise_pulses", p, 1);
    check("rst_rise_count", 32'(if_def.rise_count), 1);

    // Clean rising then falling edge.
    do_reset(1'b0);
    run_edge(1'b0, 3, fd, ff, p);
    run_edge(1'b1, 10, fd, ff, p);
    check("clean_rise_latency", fd, 5);
    check("sweep_fast_latency", ff, 3);
    check("clean_rise_pulses", p, 1);
    run_edge(1'b0, 10, fd, ff, p);
    check("clean_fall_latency", fd, 5);
    check("clean_fall_pulses", p, 1);
    check("clean_count_after_fall", 32'(if_def.rise_count), 1);

    // Bounce, then hold high.
    do_reset(1'b0);
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    run_edge(1'b1, 12, fd, ff, p);
    check("bounce_latency", fd, 5);
    check("bounce_pulses", p, 1);
    check("bounce_count", 32'(if_def.rise_count), 1);

    // Short glitch, shorter than the debounce window.
    do_reset(1'b0);
    run_edge(1'b1, 3, fd, ff, p);
    check("glitch_never_high", fd, -1);
    run_edge(1'b0, 12, fd, ff, p2);
    check("glitch_pulses", p + p2, 0);
    check("glitch_out", 32'(if_def.data_out), 0);
    check("glitch_cnt", 32'(u_def.cnt_q), 0);

    // Wrap of the 2-bit counter.
    do_reset(1'b0);
    for (int r = 0; r < 5; r++) begin
      run_edge(1'b1, 8, fd, ff, p);
      check($sformatf("wrap_count_%0d", r), 32'(if_wrap.rise_count), exp_wrap[r]);
      run_edge(1'b0, 8, fd, ff, p);
    end

    // Mid-operation asynchronous reset while a fall is being debounced.
    do_reset(1'b0);
    run_edge(1'b1, 8, fd, ff, p);
    guard = 0;
    while (m_cnt[0] != 2 && guard < 10) begin
      step(1'b0);
      guard++;
    end
    check("midrst_reach_cnt2", 32'(u_def.cnt_q), 2);
    check("midrst_out_high", 32'(if_def.data_out), 1);
    #0.5 reset_n = 1'b0;
    model_reset();
    #0.2;
    check("midrst_out", 32'(if_def.data_out), 0);
    check("midrst_cnt", 32'(u_def.cnt_q), 0);
    check("midrst_count", 32'(if_def.rise_count), 0);
    check("midrst_fall", 32'(if_def.fall), 0);
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;
    #0.3 compare_all();
    run_edge(1'b0, 8, fd, ff, p);
    check("midrst_no_fall", p, 0);

    // Randomized run lengths, with one asynchronous reset in the middle.
    do_reset(1'($urandom_range(0, 1)));
    d = 1'($urandom_range(0, 1));
    for (int r = 0; r < 60; r++) begin
      d = ~d;
      repeat ($urandom_range(1, 9)) step(d);
      if (r == 30) begin
        #0.5 reset_n = 1'b0;
        model_reset();
        #0.2 compare_all();
        @(negedge clk);
        reset_n = 1'b1;
        #0.3 compare_all();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
